sha256_compress: RTL

- Compression stage directly downstream of the message-expansion block.
- Consumes the W[0..63] schedule, one 32-bit word per cycle, and runs the 64 SHA-256 rounds on working registers a..h.
- Adds the result into the chaining value H0..H7 and presents the 256-bit digest.
- Chaining value persists across blocks, so multi-block messages are handled by the top-level controller issuing successive starts.

---
 rtl/sha256_pkg.sv | 54 +++++
 rtl/sha256_compress_if.sv | 34 +++
 rtl/sha256_round.sv | 35 +++
 rtl/sha256_compress.sv | 120 ++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 compression definitions: state encoding, working-register
// layout, round constants, initial hash values.
package sha256_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ROUNDS     = 64;
    localparam int unsigned CNT_W      = 7;
    localparam int unsigned DIGEST_W   = 8 * DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_DONE
    } state_e;

    // Working registers; a sits in the top word so the layout matches H0..H7.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] c;
        logic [DATA_WIDTH-1:0] d;
        logic [DATA_WIDTH-1:0] e;
        logic [DATA_WIDTH-1:0] f;
        logic [DATA_WIDTH-1:0] g;
        logic [DATA_WIDTH-1:0] h;
    } work_t;

    localparam logic [DIGEST_W-1:0] IV_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [DIGEST_W-1:0] IV_224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    // K[0] occupies the top word of the table.
    localparam logic [ROUNDS*DATA_WIDTH-1:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    // Round constant K[t]; word (63 - t) counted from the LSB, i.e. ~t for 6 bits.
    function automatic logic [DATA_WIDTH-1:0] k_const(input logic [5:0] t);
        return K_TABLE[{~t, 5'b00000} +: DATA_WIDTH];
    endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Schedule-in / digest-out bundle between the expansion block, the top-level
// controller and sha256_compress. SHA224_EN adds mode_224_in.
interface sha256_compress_if;
    import sha256_pkg::*;

    logic                  start_in;
    logic                  first_block_in;
    logic                  w_valid_in;
    logic [DATA_WIDTH-1:0] w_in;
    logic [CNT_W-1:0]      round_count_out;
    logic                  busy_out;
    logic                  done_out;
    logic [DIGEST_W-1:0]   digest_out;
`ifdef SHA224_EN
    logic                  mode_224_in;
`endif

    modport slave (
`ifdef SHA224_EN
        input  mode_224_in,
`endif
        input  start_in, first_block_in, w_valid_in, w_in,
        output round_count_out, busy_out, done_out, digest_out
    );

    modport master (
`ifdef SHA224_EN
        output mode_224_in,
`endif
        output start_in, first_block_in, w_valid_in, w_in,
        input  round_count_out, busy_out, done_out, digest_out
    );

endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: Sigma0/Sigma1, Ch, Maj and the a..h shift.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t                 cur_i,
    input  logic [DATA_WIDTH-1:0] k_i,
    input  logic [DATA_WIDTH-1:0] w_i,
    output work_t                 next_c_o
);

    logic [DATA_WIDTH-1:0] sig0;
    logic [DATA_WIDTH-1:0] sig1;
    logic [DATA_WIDTH-1:0] ch;
    logic [DATA_WIDTH-1:0] maj;
    logic [DATA_WIDTH-1:0] t1;
    logic [DATA_WIDTH-1:0] t2;

    // Sigma functions are fixed rotations: plain rewiring.
    assign sig0 = {cur_i.a[1:0],  cur_i.a[31:2]}
                ^ {cur_i.a[12:0], cur_i.a[31:13]}
                ^ {cur_i.a[21:0], cur_i.a[31:22]};
    assign sig1 = {cur_i.e[5:0],  cur_i.e[31:6]}
                ^ {cur_i.e[10:0], cur_i.e[31:11]}
                ^ {cur_i.e[24:0], cur_i.e[31:25]};
    assign ch   = (cur_i.e & cur_i.f) ^ (~cur_i.e & cur_i.g);
    assign maj  = (cur_i.a & cur_i.b) ^ (cur_i.a & cur_i.c) ^ (cur_i.b & cur_i.c);

    assign t1 = cur_i.h + sig1 + ch + k_i + w_i;
    assign t2 = sig0 + maj;

    // Shift the working registers, injecting T1/T2 at a and e.
    assign next_c_o = work_t'({t1 + t2, cur_i.a, cur_i.b, cur_i.c,
                               cur_i.d + t1, cur_i.e, cur_i.f, cur_i.g});

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression: consumes W[0..63] one word per valid cycle, runs 64
// rounds on a..h and accumulates into the persistent chaining value H.
// Optional SHA224_EN: mode_224_in selects the SHA-224 IV and zeroes digest[31:0].
module sha256_compress
    import sha256_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    sha256_compress_if.slave  bus
);

    state_e              state_q;
    logic [DIGEST_W-1:0] h_q;
    work_t               work_q;
    work_t               round_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                first_q;
    logic [DIGEST_W-1:0] iv_sel;
    logic [DIGEST_W-1:0] work_vec;
    logic [DIGEST_W-1:0] h_sum_d;
`ifdef SHA224_EN
    logic                mode_q;
    logic                mask_q;

    assign iv_sel = mode_q ? IV_224 : IV_256;
`else
    assign iv_sel = IV_256;
`endif

    sha256_round u_round (
        .cur_i    (work_q),
        .k_i      (k_const(cnt_q[5:0])),
        .w_i      (bus.w_in),
        .next_c_o (round_d)
    );

    assign work_vec = work_q;

    // Per-word chaining addition H_i + working_i, mod 2^32.
    always_comb begin
        h_sum_d = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum_d[i*DATA_WIDTH +: DATA_WIDTH] = h_q[i*DATA_WIDTH +: DATA_WIDTH]
                                                + work_vec[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Control FSM, round counter, working registers and chaining value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            h_q     <= IV_256;
            work_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            first_q <= 1'b0;
`ifdef SHA224_EN
            mode_q  <= 1'b0;
            mask_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start_in) begin
                        state_q <= ST_LOAD;
                        first_q <= bus.first_block_in;
`ifdef SHA224_EN
                        mode_q  <= bus.mode_224_in;
`endif
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (first_q) begin
                        h_q    <= iv_sel;
                        work_q <= work_t'(iv_sel);
                    end else begin
                        work_q <= work_t'(h_q);
                    end
`ifdef SHA224_EN
                    mask_q  <= mode_q;
`endif
                    cnt_q   <= '0;
                    state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (bus.w_valid_in) begin
                        work_q <= round_d;
                        cnt_q  <= cnt_q + 7'd1;
                        if (cnt_q == CNT_W'(ROUNDS - 1)) begin
                            state_q <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    h_q     <= h_sum_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.round_count_out = cnt_q;
    assign bus.busy_out        = busy_q;
    assign bus.done_out        = done_q;
`ifdef SHA224_EN
    assign bus.digest_out      = mask_q ? {h_q[DIGEST_W-1:DATA_WIDTH], 32'h0} : h_q;
`else
    assign bus.digest_out      = h_q;
`endif

endmodule
